// File: rtl/clock_set_ctrl_if.sv
// Requester, converter and committed-value bundle for the clock set sequencer.
// Zero latency: plain wires; no storage of its own.
// No backpressure: requests are level-held until the matching done pulse.
//
// Port summary:
//   time_req/time_bcd, alarm_req/alarm_bcd : requesters (held until done)
//   conv_bcd/conv_bin                      : shared BCD-to-binary converter
//   busy, err, *_done, *_wr                : status and strobes
//   hour_bin..alarm_min_bin                : committed values
interface clock_set_ctrl_if;
    logic        time_req;
    logic [23:0] time_bcd;
    logic        alarm_req;
    logic [15:0] alarm_bcd;
    logic [7:0]  conv_bcd;
    logic [5:0]  conv_bin;
    logic        busy;
    logic        time_done;
    logic        alarm_done;
    logic        err;
    logic        time_wr;
    logic        alarm_wr;
    logic [4:0]  hour_bin;
    logic [5:0]  min_bin;
    logic [5:0]  sec_bin;
    logic [4:0]  alarm_hour_bin;
    logic [5:0]  alarm_min_bin;

    // Sequencer side
    modport slave (
        input  time_req, time_bcd, alarm_req, alarm_bcd, conv_bin,
        output conv_bcd, busy, time_done, alarm_done, err, time_wr, alarm_wr,
               hour_bin, min_bin, sec_bin, alarm_hour_bin, alarm_min_bin
    );

    // Requester / converter side
    modport master (
        output time_req, time_bcd, alarm_req, alarm_bcd, conv_bin,
        input  conv_bcd, busy, time_done, alarm_done, err, time_wr, alarm_wr,
               hour_bin, min_bin, sec_bin, alarm_hour_bin, alarm_min_bin
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Arbitrates time-set/alarm-set onto the shared BCD-to-binary converter, validates and commits.
// Latency: commit edge = grant + 2 + fields*(CONV_LAT+1); rejected data completes at grant + 1.
// Backpressure: requests wait in IDLE while busy; the just-served requester is held off one cycle.
//
// Ports: clk (rising edge), reset (async, active-low), bus (clock_set_ctrl_if.slave).
module clock_set_ctrl #(
    parameter int         CONV_LAT     = 1,
    parameter logic [7:0] HOUR_MAX_BCD = 8'h23
) (
    input  logic             clk,
    input  logic             reset,
    clock_set_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_CAPT,
        S_COMMIT
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(CONV_LAT - 1);

    state_t      state_q, state_d;
    logic [23:0] word_q, word_d;            // latched {HH,MM,SS}; alarm uses SS=00
    logic        gnt_alarm_q, gnt_alarm_d;  // 0: time owns the sequence, 1: alarm
    logic        last_alarm_q, last_alarm_d;// round-robin pointer: who was served last
    logic [1:0]  fld_q, fld_d;              // 0 hour, 1 minute, 2 second
    logic [1:0]  wcnt_q, wcnt_d;
    logic [7:0]  conv_q, conv_d;
    logic [4:0]  stg_hour_q, stg_hour_d;
    logic [5:0]  stg_min_q, stg_min_d;
    logic [5:0]  stg_sec_q, stg_sec_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        time_done_q, time_done_d;
    logic        alarm_done_q, alarm_done_d;
    logic        time_wr_q, time_wr_d;
    logic        alarm_wr_q, alarm_wr_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [4:0]  ahour_q, ahour_d;
    logic [5:0]  amin_q, amin_d;

    logic        time_elig, alarm_elig, pick_alarm;
    logic [1:0]  last_fld;

    // Digit limits; an alarm word carries SS=00 so the seconds checks pass trivially.
    function automatic logic word_ok(input logic [23:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (w[23:16] > HOUR_MAX_BCD) ok = 1'b0;
        if (w[15:12] > 4'd5 || w[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    // A requester whose done is high this cycle is not eligible (one-cycle holdoff).
    assign time_elig  = bus.time_req  & ~time_done_q;
    assign alarm_elig = bus.alarm_req & ~alarm_done_q;
    assign pick_alarm = alarm_elig & (~time_elig | ~last_alarm_q);
    assign last_fld   = gnt_alarm_q ? 2'd1 : 2'd2;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        gnt_alarm_d  = gnt_alarm_q;
        last_alarm_d = last_alarm_q;
        fld_d        = fld_q;
        wcnt_d       = wcnt_q;
        conv_d       = conv_q;
        stg_hour_d   = stg_hour_q;
        stg_min_d    = stg_min_q;
        stg_sec_d    = stg_sec_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        time_done_d  = 1'b0;
        alarm_done_d = 1'b0;
        time_wr_d    = 1'b0;
        alarm_wr_d   = 1'b0;
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        ahour_d      = ahour_q;
        amin_d       = amin_q;

        case (state_q)
            S_IDLE: begin
                if (time_elig || alarm_elig) begin
                    gnt_alarm_d  = pick_alarm;
                    last_alarm_d = pick_alarm;
                    word_d       = pick_alarm ? {bus.alarm_bcd, 8'h00} : bus.time_bcd;
                    busy_d       = 1'b1;
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!word_ok(word_q)) begin
                    err_d        = 1'b1;
                    time_done_d  = ~gnt_alarm_q;
                    alarm_done_d = gnt_alarm_q;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    conv_d  = word_q[23:16];
                    fld_d   = 2'd0;
                    wcnt_d  = 2'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == LAT_LAST) begin
                    state_d = S_CAPT;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_CAPT: begin
                case (fld_q)
                    2'd0:    stg_hour_d = bus.conv_bin[4:0];
                    2'd1:    stg_min_d  = bus.conv_bin;
                    default: stg_sec_d  = bus.conv_bin;
                endcase
                if (fld_q == last_fld) begin
                    state_d = S_COMMIT;
                end else begin
                    fld_d   = fld_q + 2'd1;
                    conv_d  = (fld_q == 2'd0) ? word_q[15:8] : word_q[7:0];
                    wcnt_d  = 2'd0;
                    state_d = S_WAIT;
                end
            end
            S_COMMIT: begin
                if (gnt_alarm_q) begin
                    ahour_d      = stg_hour_q;
                    amin_d       = stg_min_q;
                    alarm_wr_d   = 1'b1;
                    alarm_done_d = 1'b1;
                end else begin
                    hour_d      = stg_hour_q;
                    min_d       = stg_min_q;
                    sec_d       = stg_sec_q;
                    time_wr_d   = 1'b1;
                    time_done_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            gnt_alarm_q  <= 1'b0;
            last_alarm_q <= 1'b1;   // "alarm served last" so time wins first
            fld_q        <= '0;
            wcnt_q       <= '0;
            conv_q       <= '0;
            stg_hour_q   <= '0;
            stg_min_q    <= '0;
            stg_sec_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            time_done_q  <= 1'b0;
            alarm_done_q <= 1'b0;
            time_wr_q    <= 1'b0;
            alarm_wr_q   <= 1'b0;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            ahour_q      <= '0;
            amin_q       <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            gnt_alarm_q  <= gnt_alarm_d;
            last_alarm_q <= last_alarm_d;
            fld_q        <= fld_d;
            wcnt_q       <= wcnt_d;
            conv_q       <= conv_d;
            stg_hour_q   <= stg_hour_d;
            stg_min_q    <= stg_min_d;
            stg_sec_q    <= stg_sec_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            time_done_q  <= time_done_d;
            alarm_done_q <= alarm_done_d;
            time_wr_q    <= time_wr_d;
            alarm_wr_q   <= alarm_wr_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            ahour_q      <= ahour_d;
            amin_q       <= amin_d;
        end
    end

    assign bus.conv_bcd       = conv_q;
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;
    assign bus.time_done      = time_done_q;
    assign bus.alarm_done     = alarm_done_q;
    assign bus.time_wr        = time_wr_q;
    assign bus.alarm_wr       = alarm_wr_q;
    assign bus.hour_bin       = hour_q;
    assign bus.min_bin        = min_q;
    assign bus.sec_bin        = sec_q;
    assign bus.alarm_hour_bin = ahour_q;
    assign bus.alarm_min_bin  = amin_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: one DUT with a 1-stage converter, one with a 3-stage converter.
// Latency: checks strobes and values at exact edge offsets from the grant edge.
// Backpressure: requests are held until their done pulse, as a real requester would.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    clock_set_ctrl_if bus1();
    clock_set_ctrl_if bus3();

    clock_set_ctrl #(.CONV_LAT(1), .HOUR_MAX_BCD(8'h23)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    clock_set_ctrl #(.CONV_LAT(3), .HOUR_MAX_BCD(8'h23)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    function automatic logic [5:0] bcd2bin(input logic [7:0] b);
        return 6'({2'b00, b[7:4]} * 6'd10 + {2'b00, b[3:0]});
    endfunction

    // Registered converter models: 1 stage and 3 stages.
    logic [5:0] c1_q;
    logic [5:0] c3_q [3];
    always_ff @(posedge clk) c1_q <= bcd2bin(bus1.conv_bcd);
    always_ff @(posedge clk) begin
        c3_q[0] <= bcd2bin(bus3.conv_bcd);
        c3_q[1] <= c3_q[0];
        c3_q[2] <= c3_q[1];
    end
    assign bus1.conv_bin = c1_q;
    assign bus3.conv_bin = c3_q[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus1.busy, bus1.err, bus1.time_done, bus1.alarm_done, bus1.time_wr, bus1.alarm_wr,
             bus1.hour_bin, bus1.min_bin, bus1.sec_bin, bus1.alarm_hour_bin, bus1.alarm_min_bin,
             bus1.conv_bcd} !== 42'd0) begin
            bad++; $display("FAIL reset_outputs_lat1 got nonzero busy=%b conv=%h", bus1.busy, bus1.conv_bcd);
        end
        total++;
        if ({bus3.busy, bus3.time_wr, bus3.hour_bin, bus3.conv_bcd} !== 15'd0) begin
            bad++; $display("FAIL reset_outputs_lat3 busy=%b wr=%b hour=%0d conv=%h exp all 0",
                            bus3.busy, bus3.time_wr, bus3.hour_bin, bus3.conv_bcd);
        end
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if ({bus1.busy, bus1.time_done, bus1.time_wr} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset busy/done/wr=%b exp 000",
                            {bus1.busy, bus1.time_done, bus1.time_wr});
        end
    endtask

    task automatic test_time_set();
        bus1.time_bcd = 24'h235959;
        bus1.time_req = 1'b1;
        tick();  // grant edge G
        total++;
        if (bus1.busy !== 1'b1 || bus1.conv_bcd !== 8'h00) begin
            bad++; $display("FAIL time_grant busy=%b conv=%h exp busy=1 conv=00", bus1.busy, bus1.conv_bcd);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1 || k == 3 || k == 5) begin
                total++;
                if (bus1.conv_bcd !== ((k == 1) ? 8'h23 : 8'h59)) begin
                    bad++; $display("FAIL time_conv_seq k=%0d got=%h", k, bus1.conv_bcd);
                end
            end
            total++;
            if ({bus1.busy, bus1.time_wr, bus1.time_done, bus1.err, bus1.alarm_wr} !==
                {k < 8, k == 8, k == 8, 1'b0, 1'b0}) begin
                bad++; $display("FAIL time_strobes k=%0d busy/wr/done/err/awr=%b", k,
                                {bus1.busy, bus1.time_wr, bus1.time_done, bus1.err, bus1.alarm_wr});
            end
            if (k == 7) begin
                total++;
                if ({bus1.hour_bin, bus1.min_bin, bus1.sec_bin} !== 17'd0) begin
                    bad++; $display("FAIL time_early_update h=%0d m=%0d s=%0d exp 0 0 0",
                                    bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
                end
            end
            if (k == 8) begin
                total++;
                if (bus1.hour_bin !== 5'd23 || bus1.min_bin !== 6'd59 || bus1.sec_bin !== 6'd59) begin
                    bad++; $display("FAIL time_values h=%0d m=%0d s=%0d exp 23 59 59",
                                    bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
                end
                bus1.time_req = 1'b0;
            end
        end
        tick();
        total++;
        if ({bus1.busy, bus1.time_wr, bus1.time_done} !== 3'b000 || bus1.hour_bin !== 5'd23) begin
            bad++; $display("FAIL time_after_commit busy/wr/done=%b hour=%0d exp 000 23",
                            {bus1.busy, bus1.time_wr, bus1.time_done}, bus1.hour_bin);
        end
    endtask

    task automatic test_alarm_set();
        bus1.alarm_bcd = 16'h0730;
        bus1.alarm_req = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1 || k == 3) begin
                total++;
                if (bus1.conv_bcd !== ((k == 1) ? 8'h07 : 8'h30)) begin
                    bad++; $display("FAIL alarm_conv_seq k=%0d got=%h", k, bus1.conv_bcd);
                end
            end
            total++;
            if ({bus1.busy, bus1.alarm_wr, bus1.alarm_done, bus1.time_wr, bus1.err} !==
                {k < 6, k == 6, k == 6, 1'b0, 1'b0}) begin
                bad++; $display("FAIL alarm_strobes k=%0d busy/awr/adone/twr/err=%b", k,
                                {bus1.busy, bus1.alarm_wr, bus1.alarm_done, bus1.time_wr, bus1.err});
            end
            if (k == 6) begin
                total++;
                if (bus1.alarm_hour_bin !== 5'd7 || bus1.alarm_min_bin !== 6'd30) begin
                    bad++; $display("FAIL alarm_values h=%0d m=%0d exp 7 30",
                                    bus1.alarm_hour_bin, bus1.alarm_min_bin);
                end
                total++;
                if (bus1.hour_bin !== 5'd23 || bus1.min_bin !== 6'd59 || bus1.sec_bin !== 6'd59) begin
                    bad++; $display("FAIL alarm_time_kept h=%0d m=%0d s=%0d exp 23 59 59",
                                    bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
                end
                bus1.alarm_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_bad_time(input logic [23:0] w);
        bus1.time_bcd = w;
        bus1.time_req = 1'b1;
        tick();  // G
        total++;
        if (bus1.busy !== 1'b1 || bus1.err !== 1'b0) begin
            bad++; $display("FAIL bad_grant w=%h busy=%b err=%b exp 1 0", w, bus1.busy, bus1.err);
        end
        tick();  // G+1: abort edge
        total++;
        if ({bus1.err, bus1.time_done, bus1.time_wr, bus1.busy, bus1.alarm_done} !== 5'b11000) begin
            bad++; $display("FAIL bad_abort w=%h err/done/wr/busy/adone=%b exp 11000", w,
                            {bus1.err, bus1.time_done, bus1.time_wr, bus1.busy, bus1.alarm_done});
        end
        total++;
        if (bus1.hour_bin !== 5'd23 || bus1.min_bin !== 6'd59 || bus1.sec_bin !== 6'd59) begin
            bad++; $display("FAIL bad_kept w=%h h=%0d m=%0d s=%0d exp 23 59 59", w,
                            bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
        end
        bus1.time_req = 1'b0;
        tick();
        total++;
        if ({bus1.err, bus1.time_done, bus1.time_wr} !== 3'b000 || bus1.conv_bcd !== 8'h30) begin
            bad++; $display("FAIL bad_after w=%h err/done/wr=%b conv=%h exp 000 30", w,
                            {bus1.err, bus1.time_done, bus1.time_wr}, bus1.conv_bcd);
        end
    endtask

    task automatic test_simultaneous();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        bus1.time_bcd  = 24'h101112;
        bus1.alarm_bcd = 16'h0605;
        bus1.time_req  = 1'b1;
        bus1.alarm_req = 1'b1;
        tick();  // G
        for (int k = 1; k <= 15; k++) begin
            tick();
            total++;
            if ({bus1.time_wr, bus1.alarm_wr, bus1.busy} !== {k == 8, k == 15, (k != 8) && (k != 15)}) begin
                bad++; $display("FAIL simul_strobes k=%0d twr/awr/busy=%b", k,
                                {bus1.time_wr, bus1.alarm_wr, bus1.busy});
            end
            if (k == 8) begin
                total++;
                if (bus1.hour_bin !== 5'd10 || bus1.min_bin !== 6'd11 || bus1.sec_bin !== 6'd12) begin
                    bad++; $display("FAIL simul_time h=%0d m=%0d s=%0d exp 10 11 12",
                                    bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
                end
                bus1.time_req = 1'b0;
            end
            if (k == 10) begin
                total++;
                if (bus1.conv_bcd !== 8'h06) begin
                    bad++; $display("FAIL simul_alarm_grant conv=%h exp 06", bus1.conv_bcd);
                end
            end
            if (k == 15) begin
                total++;
                if (bus1.alarm_hour_bin !== 5'd6 || bus1.alarm_min_bin !== 6'd5) begin
                    bad++; $display("FAIL simul_alarm h=%0d m=%0d exp 6 5",
                                    bus1.alarm_hour_bin, bus1.alarm_min_bin);
                end
                bus1.alarm_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_alternate();
        bus1.time_bcd  = 24'h101112;
        bus1.alarm_bcd = 16'h0809;
        bus1.time_req  = 1'b1;
        bus1.alarm_req = 1'b1;
        tick();  // G: time first (alarm was served last)
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) bus1.time_bcd = 24'h131415;  // only the next time grant may see this
            total++;
            if ({bus1.time_wr, bus1.alarm_wr, bus1.busy} !==
                {(k == 8) || (k == 24), k == 15, (k != 8) && (k != 15) && (k != 24)}) begin
                bad++; $display("FAIL alt_strobes k=%0d twr/awr/busy=%b", k,
                                {bus1.time_wr, bus1.alarm_wr, bus1.busy});
            end
            if (k == 8) begin
                total++;
                if (bus1.hour_bin !== 5'd10 || bus1.sec_bin !== 6'd12) begin
                    bad++; $display("FAIL alt_time1 h=%0d s=%0d exp 10 12", bus1.hour_bin, bus1.sec_bin);
                end
            end
            if (k == 15) begin
                total++;
                if (bus1.alarm_hour_bin !== 5'd8 || bus1.alarm_min_bin !== 6'd9) begin
                    bad++; $display("FAIL alt_alarm h=%0d m=%0d exp 8 9",
                                    bus1.alarm_hour_bin, bus1.alarm_min_bin);
                end
            end
            if (k == 24) begin
                total++;
                if (bus1.hour_bin !== 5'd13 || bus1.min_bin !== 6'd14 || bus1.sec_bin !== 6'd15) begin
                    bad++; $display("FAIL alt_time2 h=%0d m=%0d s=%0d exp 13 14 15",
                                    bus1.hour_bin, bus1.min_bin, bus1.sec_bin);
                end
                bus1.time_req  = 1'b0;
                bus1.alarm_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus1.time_bcd = 24'h235959;
        bus1.time_req = 1'b1;
        tick();             // G
        repeat (4) tick();  // G+4
        reset = 1'b0;
        #1;
        total++;
        if ({bus1.busy, bus1.time_wr, bus1.time_done, bus1.hour_bin, bus1.min_bin, bus1.sec_bin,
             bus1.alarm_hour_bin, bus1.alarm_min_bin, bus1.conv_bcd} !== 39'd0) begin
            bad++; $display("FAIL mid_reset_clear busy=%b h=%0d ah=%0d conv=%h exp 0",
                            bus1.busy, bus1.hour_bin, bus1.alarm_hour_bin, bus1.conv_bcd);
        end
        bus1.time_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({bus1.busy, bus1.time_wr, bus1.time_done, bus1.alarm_wr, bus1.alarm_done, bus1.err} !== 6'd0
                || bus1.hour_bin !== 5'd0) begin
                bad++; $display("FAIL mid_reset_quiet k=%0d strobes=%b hour=%0d", k,
                                {bus1.busy, bus1.time_wr, bus1.time_done, bus1.alarm_wr,
                                 bus1.alarm_done, bus1.err}, bus1.hour_bin);
            end
        end
        bus1.alarm_bcd = 16'h2359;
        bus1.alarm_req = 1'b1;
        tick();
        repeat (6) tick();
        total++;
        if (bus1.alarm_wr !== 1'b1 || bus1.alarm_hour_bin !== 5'd23 || bus1.alarm_min_bin !== 6'd59) begin
            bad++; $display("FAIL mid_reset_resume awr=%b h=%0d m=%0d exp 1 23 59",
                            bus1.alarm_wr, bus1.alarm_hour_bin, bus1.alarm_min_bin);
        end
        bus1.alarm_req = 1'b0;
        tick();
    endtask

    task automatic test_conv_lat3();
        bus3.time_bcd = 24'h010203;
        bus3.time_req = 1'b1;
        tick();  // G
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1 || k == 5 || k == 9) begin
                total++;
                if (bus3.conv_bcd !== ((k == 1) ? 8'h01 : (k == 5) ? 8'h02 : 8'h03)) begin
                    bad++; $display("FAIL lat3_conv_seq k=%0d got=%h", k, bus3.conv_bcd);
                end
            end
            total++;
            if ({bus3.busy, bus3.time_wr, bus3.time_done} !== {k < 14, k == 14, k == 14}) begin
                bad++; $display("FAIL lat3_strobes k=%0d busy/wr/done=%b", k,
                                {bus3.busy, bus3.time_wr, bus3.time_done});
            end
            if (k == 14) begin
                total++;
                if (bus3.hour_bin !== 5'd1 || bus3.min_bin !== 6'd2 || bus3.sec_bin !== 6'd3) begin
                    bad++; $display("FAIL lat3_values h=%0d m=%0d s=%0d exp 1 2 3",
                                    bus3.hour_bin, bus3.min_bin, bus3.sec_bin);
                end
                bus3.time_req = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        bus1.time_req  = 1'b0;
        bus1.time_bcd  = '0;
        bus1.alarm_req = 1'b0;
        bus1.alarm_bcd = '0;
        bus3.time_req  = 1'b0;
        bus3.time_bcd  = '0;
        bus3.alarm_req = 1'b0;
        bus3.alarm_bcd = '0;
        #1;
        test_reset();
        test_time_set();
        test_alarm_set();
        test_bad_time(24'h246000);
        test_bad_time(24'h12A000);
        test_bad_time(24'h126000);
        test_simultaneous();
        test_alternate();
        test_reset_mid();
        test_conv_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Sequencer and arbiter for the shared registered BCD-to-binary converter in the clock datapath. Two requesters share the converter: time-set (HH:MM:SS) and alarm-set (HH:MM). The block validates the BCD digits and feeds the fields one at a time through the converter. It captures the 6-bit results and commits them to the clock or alarm registers with a one-cycle write strobe.

## Interface
- CONV_LAT, 1: converter register stages (cycles from conv_bcd change to valid conv_bin); legal 1..3
- HOUR_MAX_BCD, 8'h23: largest legal hour value, in BCD
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- time_req  in  1  time-set request; held high until time_done
- time_bcd  in  24  {HH,MM,SS} packed BCD; sampled only at grant edge
- alarm_req  in  1  alarm-set request; held high until alarm_done
- alarm_bcd  in  16  {HH,MM} packed BCD; sampled only at grant edge
- conv_bcd  out  8  registered operand to shared converter
- conv_bin  in  6  converter result
- busy  out  1  high from grant edge until commit/abort edge
- time_done, alarm_done  out  1  one-cycle completion pulse to the served requester
- err  out  1  one-cycle pulse, coincident with done, on rejected data
- time_wr, alarm_wr  out  1  one-cycle write strobe; data valid while high
- hour_bin  out 5, min_bin  out 6, sec_bin  out 6: committed time
- alarm_hour_bin  out 5, alarm_min_bin  out 6: committed alarm

## Operation
- FSM states: IDLE, CHECK, WAIT, CAPT, COMMIT.
- IDLE: when any eligible request is present, grant one requester. Latch its BCD word and grant id, set busy, go to CHECK.
- Arbitration is round-robin on simultaneous requests. The requester not served last wins. After reset, time wins.
- CHECK: validate the latched word.
  - Error conditions: any nibble > 9; hour > HOUR_MAX_BCD; minute/second tens nibble > 5.
  - Invalid: pulse done(grant) and err; no write; outputs unchanged; back to IDLE.
  - Valid: conv_bcd <= hour field; field index 0; go to WAIT.
- WAIT: stay CONV_LAT cycles, then go to CAPT.
- CAPT: capture conv_bin into the staging register for the current field. Hour uses conv_bin[4:0].
  - More fields remain: conv_bcd <= next field (min, then sec); go to WAIT.
  - Otherwise: go to COMMIT.
- COMMIT: load staging into the granted output set, pulse wr(grant) and done(grant), clear busy, go to IDLE.
- Field count is 3 for time and 2 for alarm. The alarm path never converts a seconds field.
- Holdoff: in the cycle where done(x) is high, IDLE ignores req x. The other requester may be granted in that cycle.
- Request changes while busy are ignored. A pending request on the other port waits and is granted in IDLE.
- conv_bcd holds its last value when idle.

## Timing
- Reset (asynchronous, active-low) forces:
  - State IDLE.
  - All *_bin outputs, staging registers and conv_bcd to 0.
  - busy, err, all done/wr strobes to 0.
  - Arbiter pointer to "time first".
- Reset mid-operation aborts the sequence: no strobe and no partial write.
- Grant edge G is the first edge with a req high in IDLE. Commit edge = G + 2 + N*(CONV_LAT+1), where N = field count.
  - CONV_LAT=1, time: G+8.
  - CONV_LAT=1, alarm: G+6.
  - Abort edge = G+1.
- After commit edge C, wr, done and the new output values are visible in cycle C..C+1. busy is low from C.
- Back-to-back requests: the other requester can be granted at C+1. The same requester is re-granted no earlier than C+2.
- Outputs change only at the commit edge.

## Test plan
- Reset then time_req with 24'h235959, CONV_LAT=1 -> conv_bcd sequence 23,59,59; time_wr and time_done at G+8; hour_bin=23, min_bin=59, sec_bin=59; busy high for 8 cycles.
- alarm_req with 16'h0730 -> alarm_wr at G+6; alarm_hour_bin=7, alarm_min_bin=30; time outputs unchanged.
- time_req with 24'h246000 and, separately, 24'h12A000 -> err and time_done at G+1; no time_wr; prior time values kept.
- time_req and alarm_req rise in the same cycle after reset -> time served first; alarm granted at C+1.
  - Repeat with both held: grants alternate time, alarm, time.
- Assert reset at G+4 of a time set -> all outputs 0 immediately. No wr or done after release; FSM in IDLE.
- CONV_LAT=3 build, time 24'h010203 -> commit at G+14; values 1, 2, 3.
